efuse_wb_ctrl: RTL
==================

// Module: efuse_wb_ctrl
// PURPOSE
//  Parametrised Wishbone-classic controller for the on-chip eFuse macro; successor to the stub efuse_ctrl.
//  Serves timed reads and bit-serial, enable-gated programming of one fuse word per access.
//  Sits between the management Wishbone bus and the fuse array; fuse words hold FPGA trim/ID bits.
// PARAMETERS
//  ADDR_W      11   fuse word address width
//  DATA_W      8    fuse word width; multiple of 8
//  RD_CYCLES   4    cycles fuse_rd_o is held per read (>=1)
//  PGM_CYCLES  200  cycles of one fuse_pgm_o burn pulse (>=1)
//  GAP_CYCLES  2    idle cycles after each burn pulse (>=1)
// PORTS
//  clk_i          in   1                  single clock; all logic on rising edge
//  rstn_i         in   1                  synchronous active-low reset
//  wb_cyc_i       in   1                  Wishbone cycle
//  wb_stb_i       in   1                  Wishbone strobe
//  wb_we_i        in   1                  1 = program, 0 = read
//  wb_sel_i       in   DATA_W/8           byte selects (writes only)
//  wb_adr_i       in   ADDR_W             fuse word address
//  wb_dat_i       in   DATA_W             bits to burn (1 = burn)
//  wb_dat_o       out  DATA_W             read data, held until next read
//  wb_ack_o       out  1                  one-cycle completion
//  wb_err_o       out  1                  one-cycle rejected write
//  pgm_en_i       in   1                  programming enable; 0 blocks all burns
//  busy_o         out  1                  1 whenever state != IDLE
//  fuse_addr_o    out  ADDR_W             macro word address, latched per access
//  fuse_bitsel_o  out  $clog2(DATA_W)     macro bit index during programming
//  fuse_rd_o      out  1                  macro sense enable
//  fuse_pgm_o     out  1                  macro burn pulse
//  fuse_dat_i     in   DATA_W             macro sense data
// BEHAVIOUR
//  - Reset (rstn_i=0 at an edge): state IDLE; all outputs 0 incl. wb_dat_o; counters 0.
//  - All outputs registered. Request = wb_cyc_i & wb_stb_i seen in IDLE at cycle T.
//  - States: IDLE, READ, SCAN, PULSE, GAP, ACK, ERR.
//  - Read: T latch adr -> fuse_addr_o. READ for T+1..T+RD_CYCLES with fuse_rd_o=1.
//    fuse_dat_i captured on the last READ edge. ACK at T+RD_CYCLES+1: wb_ack_o=1, wb_dat_o valid.
//    wb_sel_i ignored.
//  - Write, accepted only if pgm_en_i=1 and all wb_sel_i=1; else ERR at T+1 (wb_err_o=1 one cycle, no burn).
//  - Accepted write: latch address and data, bit index=0, go SCAN.
//  - SCAN: one cycle per bit, index 0..DATA_W-1 ascending.
//    Bit=1 -> PULSE (fuse_pgm_o=1, fuse_bitsel_o=index, PGM_CYCLES cycles) -> GAP (GAP_CYCLES) -> SCAN with next index.
//    Bit=0 -> next index.
//    After index DATA_W-1 -> ACK.
//    Write latency = DATA_W + popcount*(PGM_CYCLES+GAP_CYCLES); ACK cycle follows.
//  - fuse_bitsel_o is stable for the whole pulse. fuse_pgm_o and fuse_rd_o are never both 1.
//  - ACK/ERR: one cycle, then IDLE. A request still present in the following IDLE cycle is a new access.
//  - Requests while busy are ignored; master holds stb.
//  - wb_cyc_i drops in READ: go IDLE next edge, no ack.
//  - wb_cyc_i drops in SCAN/PULSE/GAP: finish the current pulse and gap, then IDLE. No further bits, no ack.
//  - pgm_en_i falling mid-write: same as a cyc drop.
//  - Reset mid-operation: fuse_pgm_o/fuse_rd_o low at that edge; no ack.
//  - Counters sized $clog2(max(RD,PGM,GAP)+1); no wrap permitted.
// TESTING
//  - Read adr 0x123, fuse_dat_i=0xA5 -> fuse_rd_o high T+1..T+4, fuse_addr_o=0x123, ack at T+5 with wb_dat_o=0xA5.
//  - Write 0x81, pgm_en_i=1 -> pulses 200 cycles at bitsel 0 then 7, no others; ack at T+413.
//  - Write 0x00 -> no fuse_pgm_o; ack at T+9.
//  - Write with pgm_en_i=0 or wb_sel_i=0 -> wb_err_o at T+1, no ack, fuse_pgm_o stays 0.
//  - rstn_i=0 at pulse cycle 50 of a write -> fuse_pgm_o and busy_o 0 next edge; no ack; next read works.
//  - wb_cyc_i drops mid bit-0 pulse of write 0x03 -> pulse completes, bit 1 never burned, no ack, IDLE after gap.

Source files
------------

// File: rtl/efuse_wb_ctrl.sv
// Wishbone-classic controller for the eFuse macro: timed word reads and bit-serial,
// enable-gated programming of one fuse word per access.
module efuse_wb_ctrl #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RD_CYCLES  = 4,
  parameter int unsigned PGM_CYCLES = 200,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  input  logic                      wb_we_i,
  input  logic [DATA_W/8-1:0]       wb_sel_i,
  input  logic [ADDR_W-1:0]         wb_adr_i,
  input  logic [DATA_W-1:0]         wb_dat_i,
  output logic [DATA_W-1:0]         wb_dat_o,
  output logic                      wb_ack_o,
  output logic                      wb_err_o,
  input  logic                      pgm_en_i,
  output logic                      busy_o,
  output logic [ADDR_W-1:0]         fuse_addr_o,
  output logic [$clog2(DATA_W)-1:0] fuse_bitsel_o,
  output logic                      fuse_rd_o,
  output logic                      fuse_pgm_o,
  input  logic [DATA_W-1:0]         fuse_dat_i
);

  localparam int unsigned IdxW   = $clog2(DATA_W);
  localparam int unsigned MaxRp  = (RD_CYCLES > PGM_CYCLES) ? RD_CYCLES : PGM_CYCLES;
  localparam int unsigned MaxCyc = (MaxRp > GAP_CYCLES) ? MaxRp : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  localparam logic [CntW-1:0] RdLast  = CntW'(RD_CYCLES - 1);
  localparam logic [CntW-1:0] PgmLast = CntW'(PGM_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle, StRead, StScan, StPulse, StGap, StAck, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                abort_q, abort_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic                ack_q, err_q, busy_q, rd_q, pgm_q;
  logic [IdxW-1:0]     bitsel_q, bitsel_d;
  logic                req, abort_now;

  assign req       = wb_cyc_i & wb_stb_i;
  // A dropped cycle or a withdrawn enable ends the write once any pulse in flight is done.
  assign abort_now = abort_q | ~wb_cyc_i | ~pgm_en_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    abort_d = abort_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        cnt_d   = '0;
        idx_d   = '0;
        if (req) begin
          if (!wb_we_i) begin
            addr_d  = wb_adr_i;
            state_d = StRead;
          end else if (pgm_en_i && (&wb_sel_i)) begin
            addr_d  = wb_adr_i;
            wdat_d  = wb_dat_i;
            state_d = StScan;
          end else begin
            state_d = StErr;
          end
        end
      end
      StRead: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (cnt_q == RdLast) begin
          rdat_d  = fuse_dat_i;
          cnt_d   = '0;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StScan: begin
        if (abort_now) begin
          state_d = StIdle;
        end else if (wdat_q[idx_q]) begin
          cnt_d   = '0;
          state_d = StPulse;
        end else if (idx_q == IdxLast) begin
          state_d = StAck;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StPulse: begin
        abort_d = abort_now;
        if (cnt_q == PgmLast) begin
          cnt_d   = '0;
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        abort_d = abort_now;
        if (cnt_q == GapLast) begin
          cnt_d = '0;
          if (abort_now) begin
            state_d = StIdle;
          end else if (idx_q == IdxLast) begin
            state_d = StAck;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StScan;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bitsel_d = (state_d == StPulse) ? idx_d : '0;

  // Outputs are registered decodes of the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      idx_q    <= '0;
      abort_q  <= 1'b0;
      addr_q   <= '0;
      wdat_q   <= '0;
      rdat_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      rd_q     <= 1'b0;
      pgm_q    <= 1'b0;
      bitsel_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      abort_q  <= abort_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      rdat_q   <= rdat_d;
      ack_q    <= (state_d == StAck);
      err_q    <= (state_d == StErr);
      busy_q   <= (state_d != StIdle);
      rd_q     <= (state_d == StRead);
      pgm_q    <= (state_d == StPulse);
      bitsel_q <= bitsel_d;
    end
  end

  assign wb_dat_o      = rdat_q;
  assign wb_ack_o      = ack_q;
  assign wb_err_o      = err_q;
  assign busy_o        = busy_q;
  assign fuse_addr_o   = addr_q;
  assign fuse_bitsel_o = bitsel_q;
  assign fuse_rd_o     = rd_q;
  assign fuse_pgm_o    = pgm_q;

endmodule
